// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU bus sequencer slice:
//   - sequencer state and bus-phase encodings
//   - ALU slave register map
//   - ALU flag bit positions
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU slave register map
    localparam logic [7:0] ADDR_A     = 8'h00;
    localparam logic [7:0] ADDR_B     = 8'h01;
    localparam logic [7:0] ADDR_FLAGS = 8'h02;
    localparam logic [7:0] ADDR_RES   = 8'h03;
    localparam logic [7:0] ADDR_ADD   = 8'h80;
    localparam logic [7:0] ADDR_ADDC  = 8'h81;

    // ALU flag bit positions
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 6;
    localparam int unsigned FLAG_N = 7;

    // Sequencer states
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_WR_A   = 3'd1;
    localparam state_t S_WR_B   = 3'd2;
    localparam state_t S_OP     = 3'd3;
    localparam state_t S_RD_RES = 3'd4;
    localparam state_t S_RD_FLG = 3'd5;
    localparam state_t S_RESP   = 3'd6;

    // Single-transfer bus phases
    typedef logic [1:0] phase_t;
    localparam phase_t P_IDLE = 2'd0;
    localparam phase_t P_REQ  = 2'd1;
    localparam phase_t P_WAIT = 2'd2;

    // Operation trigger address for the selected add flavour
    function automatic logic [7:0] op_addr(input logic carry);
        return carry ? ADDR_ADDC : ADDR_ADD;
    endfunction

endpackage

// File: rtl/alu_wb_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_wb_sequencer_if
// Bundles the sequencer's command, response and Wishbone master signals.
//   master : sequencer view (drives o_*, samples i_*)
//   slave  : environment view (drives i_*, samples o_*)
// Signal names keep their original i_/o_ prefixes relative to the sequencer.
// -----------------------------------------------------------------------------
interface alu_wb_sequencer_if;
    // command channel
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [7:0] i_cmd_a;
    logic [7:0] i_cmd_b;
    logic       i_cmd_carry;
    // response channel
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic [7:0] o_rsp_result;
    logic [7:0] o_rsp_flags;
    logic       o_rsp_err;
    // Wishbone pipelined master
    logic       o_wb_cyc;
    logic       o_wb_stb;
    logic       o_wb_we;
    logic [7:0] o_wb_addr;
    logic [7:0] o_wb_data;
    logic       i_wb_ack;
    logic       i_wb_stall;
    logic [7:0] i_wb_data;

    modport master (
        input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_carry, i_rsp_ready,
               i_wb_ack, i_wb_stall, i_wb_data,
        output o_cmd_ready, o_rsp_valid, o_rsp_result, o_rsp_flags, o_rsp_err,
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );

    modport slave (
        output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_carry, i_rsp_ready,
               i_wb_ack, i_wb_stall, i_wb_data,
        input  o_cmd_ready, o_rsp_valid, o_rsp_result, o_rsp_flags, o_rsp_err,
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
    );
endinterface

// File: rtl/alu_wb_sequencer_xfer.sv
// -----------------------------------------------------------------------------
// wb_single_xfer
// One Wishbone pipelined transaction: REQ (stb held until not stalled), then
// WAIT (stb low) until ack. At most one request outstanding.
// Optional macro ALU_SEQ_TIMEOUT_EN adds a WAIT-phase watchdog.
// Ports:
//   i_clk, reset_n             clock, async active-low reset
//   i_start                    load we/addr/data and enter REQ
//   i_we, i_addr, i_data       fields of the transaction being started
//   i_ack, i_stall, i_rdata    slave response signals
//   o_stb, o_we, o_addr, o_data bus request fields
//   o_done                     ack received in WAIT (single cycle)
//   o_rdata                    read data, valid with o_done
//   o_timeout                  WAIT expired without ack (single cycle)
// -----------------------------------------------------------------------------
module wb_single_xfer
    import alu_pkg::*;
`ifdef ALU_SEQ_TIMEOUT_EN
    #(parameter int unsigned TIMEOUT_CYCLES = 16)
`endif
(
    input  logic       i_clk,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_data,
    input  logic       i_ack,
    input  logic       i_stall,
    input  logic [7:0] i_rdata,
    output logic       o_stb,
    output logic       o_we,
    output logic [7:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_timeout
);

    phase_t     phase_q, phase_d;
    logic       we_q,    we_d;
    logic [7:0] addr_q,  addr_d;
    logic [7:0] data_q,  data_d;
`ifdef ALU_SEQ_TIMEOUT_EN
    logic [7:0] cnt_q,   cnt_d;
`endif

    always_comb begin
        phase_d   = phase_q;
        we_d      = we_q;
        addr_d    = addr_q;
        data_d    = data_q;
        o_done    = 1'b0;
        o_timeout = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (phase_q)
            P_REQ: begin
                // ack during REQ is never taken as completion
                if (!i_stall) begin
                    phase_d = P_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            P_WAIT: begin
                if (i_ack) begin
                    o_done  = 1'b1;
                    phase_d = P_IDLE;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                // cnt_q holds the number of WAIT cycles already elapsed
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    o_timeout = 1'b1;
                    phase_d   = P_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: ;
        endcase
        // a new start may coincide with the previous done
        if (i_start) begin
            phase_d = P_REQ;
            we_d    = i_we;
            addr_d  = i_addr;
            data_d  = i_data;
        end
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= P_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            phase_q <= phase_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef ALU_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign o_stb   = (phase_q == P_REQ);
    assign o_we    = we_q;
    assign o_addr  = addr_q;
    assign o_data  = data_q;
    assign o_rdata = i_rdata;

endmodule

// File: rtl/alu_wb_sequencer.sv
// -----------------------------------------------------------------------------
// alu_wb_sequencer
// Wishbone master driving the 8-bit ALU slave. Takes one command (A, B,
// carry-select), writes A and B, triggers add/add-with-carry, reads result
// and flags, then presents them on the response channel.
// Optional macro ALU_SEQ_TIMEOUT_EN enables a per-transaction ack watchdog
// that aborts the sequence and reports o_rsp_err.
// Ports:
//   i_clk     system clock
//   reset_n   asynchronous active-low reset
//   bus       alu_wb_sequencer_if.master: command valid/ready, response
//             valid/ready with result/flags/err, Wishbone cyc/stb/we/addr/
//             data out and ack/stall/data in
// -----------------------------------------------------------------------------
module alu_wb_sequencer
    import alu_pkg::*;
#(
    parameter logic [7:0]  RES_ADDR       = ADDR_RES,
    parameter logic [7:0]  FLAGS_ADDR     = ADDR_FLAGS,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  reset_n,
    alu_wb_sequencer_if.master    bus
);

    state_t     state_q,  state_d;
    logic [7:0] a_q,      a_d;
    logic [7:0] b_q,      b_d;
    logic       carry_q,  carry_d;
    logic       cyc_q,    cyc_d;
    logic [7:0] result_q, result_d;
    logic [7:0] flags_q,  flags_d;
`ifdef ALU_SEQ_TIMEOUT_EN
    logic       err_q,    err_d;
`endif

    logic       x_start;
    logic       x_we;
    logic [7:0] x_addr;
    logic [7:0] x_data;
    logic       x_done;
    logic [7:0] x_rdata;
    logic       x_timeout;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cyc_d    = cyc_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_SEQ_TIMEOUT_EN
        err_d    = err_q;
`endif
        x_start  = 1'b0;
        x_we     = 1'b0;
        x_addr   = '0;
        x_data   = '0;

        // Each bus state launches the following transaction in the same
        // cycle its own ack arrives, so REQ follows ack with no gap.
        case (state_q)
            S_IDLE: begin
                if (bus.i_cmd_valid) begin
                    a_d      = bus.i_cmd_a;
                    b_d      = bus.i_cmd_b;
                    carry_d  = bus.i_cmd_carry;
                    result_d = '0;
                    flags_d  = '0;
`ifdef ALU_SEQ_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    cyc_d    = 1'b1;
                    x_start  = 1'b1;
                    x_we     = 1'b1;
                    x_addr   = ADDR_A;
                    x_data   = bus.i_cmd_a;
                    state_d  = S_WR_A;
                end
            end
            S_WR_A: begin
                if (x_done) begin
                    x_start = 1'b1;
                    x_we    = 1'b1;
                    x_addr  = ADDR_B;
                    x_data  = b_q;
                    state_d = S_WR_B;
                end
            end
            S_WR_B: begin
                if (x_done) begin
                    x_start = 1'b1;
                    x_addr  = op_addr(carry_q);
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (x_done) begin
                    x_start = 1'b1;
                    x_addr  = RES_ADDR;
                    state_d = S_RD_RES;
                end
            end
            S_RD_RES: begin
                if (x_done) begin
                    result_d = x_rdata;
                    x_start  = 1'b1;
                    x_addr   = FLAGS_ADDR;
                    state_d  = S_RD_FLG;
                end
            end
            S_RD_FLG: begin
                if (x_done) begin
                    flags_d = x_rdata;
                    cyc_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ALU_SEQ_TIMEOUT_EN
        if (x_timeout) begin
            cyc_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_RESP;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cyc_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cyc_q    <= cyc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef ALU_SEQ_TIMEOUT_EN
            err_q    <= err_d;
`endif
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    wb_single_xfer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_xfer (
`else
    wb_single_xfer u_xfer (
`endif
        .i_clk     (i_clk),
        .reset_n   (reset_n),
        .i_start   (x_start),
        .i_we      (x_we),
        .i_addr    (x_addr),
        .i_data    (x_data),
        .i_ack     (bus.i_wb_ack),
        .i_stall   (bus.i_wb_stall),
        .i_rdata   (bus.i_wb_data),
        .o_stb     (bus.o_wb_stb),
        .o_we      (bus.o_wb_we),
        .o_addr    (bus.o_wb_addr),
        .o_data    (bus.o_wb_data),
        .o_done    (x_done),
        .o_rdata   (x_rdata),
        .o_timeout (x_timeout)
    );

    assign bus.o_wb_cyc     = cyc_q;
    assign bus.o_cmd_ready  = (state_q == S_IDLE);
    assign bus.o_rsp_valid  = (state_q == S_RESP);
    assign bus.o_rsp_result = result_q;
    assign bus.o_rsp_flags  = flags_q;

`ifdef ALU_SEQ_TIMEOUT_EN
    assign bus.o_rsp_err    = err_q;
`else
    assign bus.o_rsp_err    = 1'b0;
    // watchdog absent: its status and limit are intentionally not used
    logic [8:0] unused_cfg;
    assign unused_cfg = {x_timeout, 8'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_alu_wb_sequencer.sv
module tb_alu_wb_sequencer;
    import alu_pkg::*;

    localparam int TO = 16;

    logic clk;
    logic rst_n;
    alu_wb_sequencer_if bus();

    alu_wb_sequencer #(
        .RES_ADDR       (8'h03),
        .FLAGS_ADDR     (8'h02),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // slave configuration and state
    int          stall_cfg [5];
    int          ack_delay;
    bit          stray_mode;
    bit          noack_op;
    int          stall_left;
    int          pend_wait;
    int          txn_idx;
    bit          pend;
    logic [7:0]  pend_addr;
    logic [7:0]  alu_a, alu_b, alu_res, alu_flg;
    logic [16:0] stb_log [$];
    int          cyc_cnt;
    logic        ref_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ALU arithmetic: returns {result, flags}
    function automatic logic [15:0] alu_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] s;
        logic [7:0] f;
        s = {1'b0, a} + {1'b0, b} + {8'b0, cin};
        f = '0;
        f[FLAG_C] = s[8];
        f[FLAG_Z] = (s[7:0] == 8'h00);
        f[FLAG_V] = (a[7] == b[7]) && (s[7] != a[7]);
        f[FLAG_N] = s[7];
        return {s[7:0], f};
    endfunction

    // Wishbone ALU slave: observes at negedge, drives 1 time unit after posedge
    initial begin
        logic [15:0] rf;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_stall = 1'b0;
        bus.i_wb_data  = 8'h00;
        alu_a = '0; alu_b = '0; alu_res = '0; alu_flg = '0;
        pend = 0; pend_wait = 0; txn_idx = 0; stall_left = 0; cyc_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.o_wb_cyc) cyc_cnt++;
            if (bus.o_wb_stb) begin
                stb_log.push_back({bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data});
                if (bus.i_wb_stall) begin
                    if (stall_left > 0) stall_left--;
                end else begin
                    pend      = 1;
                    pend_wait = ack_delay;
                    pend_addr = bus.o_wb_addr;
                    if (bus.o_wb_we) begin
                        if (bus.o_wb_addr == ADDR_A) alu_a = bus.o_wb_data;
                        if (bus.o_wb_addr == ADDR_B) alu_b = bus.o_wb_data;
                    end else if (bus.o_wb_addr == ADDR_ADD || bus.o_wb_addr == ADDR_ADDC) begin
                        rf = alu_add(alu_a, alu_b, (bus.o_wb_addr == ADDR_ADDC) ? alu_flg[FLAG_C] : 1'b0);
                        alu_res = rf[15:8];
                        alu_flg = rf[7:0];
                    end
                end
            end
            @(posedge clk);
            #1;
            bus.i_wb_stall = (stall_left > 0);
            bus.i_wb_ack   = stray_mode;
            bus.i_wb_data  = 8'hEE;
            if (pend) begin
                pend_wait--;
                if (pend_wait == 0) begin
                    pend = 0;
                    if (!(noack_op && (pend_addr == ADDR_ADD || pend_addr == ADDR_ADDC))) begin
                        bus.i_wb_ack  = 1'b1;
                        bus.i_wb_data = (pend_addr == ADDR_RES)   ? alu_res :
                                        (pend_addr == ADDR_FLAGS) ? alu_flg : 8'h55;
                        txn_idx++;
                        stall_left = (txn_idx < 5) ? stall_cfg[txn_idx] : 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_default();
        for (int k = 0; k < 5; k++) stall_cfg[k] = 0;
        ack_delay  = 1;
        stray_mode = 0;
        noack_op   = 0;
    endtask

    task automatic slave_clear();
        stb_log.delete();
        cyc_cnt    = 0;
        pend       = 0;
        txn_idx    = 0;
        stall_left = stall_cfg[0];
    endtask

    // Runs one command from IDLE (called just after a posedge) through the
    // response handshake; ends at a negedge with the sequencer back in IDLE.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic c, input int hold);
        logic [15:0] rf;
        logic [7:0]  er, ef;
        logic        ee;
        logic [16:0] fld [5];
        logic [16:0] exp_q [$];
        logic [16:0] obs;
        int          ntx, lat, exp_lat;

        rf = alu_add(a, b, c ? ref_c : 1'b0);
        er = rf[15:8];
        ef = rf[7:0];
        ee = 1'b0;
        ref_c = ef[FLAG_C];
        fld[0] = {1'b1, ADDR_A, a};
        fld[1] = {1'b1, ADDR_B, b};
        fld[2] = {1'b0, (c ? ADDR_ADDC : ADDR_ADD), 8'h00};
        fld[3] = {1'b0, ADDR_RES, 8'h00};
        fld[4] = {1'b0, ADDR_FLAGS, 8'h00};
        ntx = noack_op ? 3 : 5;
        exp_lat = 1;
        for (int k = 0; k < ntx; k++) begin
            exp_lat += 1 + stall_cfg[k] + ((noack_op && k == 2) ? TO : ack_delay);
            for (int s = 0; s <= stall_cfg[k]; s++) exp_q.push_back(fld[k]);
        end
        if (noack_op) begin
            er = 8'h00; ef = 8'h00; ee = 1'b1;
        end

        slave_clear();
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = a;
        bus.i_cmd_b     = b;
        bus.i_cmd_carry = c;
        @(negedge clk);
        chk("cmd_ready_idle", bus.o_cmd_ready, 1);
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_a     = 8'($urandom);
        bus.i_cmd_b     = 8'($urandom);
        bus.i_cmd_carry = 1'($urandom);
        lat = 1;
        forever begin
            @(negedge clk);
            if (bus.o_rsp_valid === 1'b1 || lat > 400) break;
            tick();
            lat++;
        end
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_result", bus.o_rsp_result, er);
        chk("rsp_flags", bus.o_rsp_flags, ef);
        chk("rsp_err", bus.o_rsp_err, ee);

        repeat (hold) begin
            tick();
            @(negedge clk);
            chk("hold_valid", bus.o_rsp_valid, 1);
            chk("hold_result", {bus.o_rsp_result, bus.o_rsp_flags}, {er, ef});
            chk("hold_cmd_ready", bus.o_cmd_ready, 0);
            chk("hold_bus_idle", {bus.o_wb_cyc, bus.o_wb_stb}, 0);
        end
        tick();
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        chk("hs_cmd_ready", bus.o_cmd_ready, 0);
        tick();
        bus.i_rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", bus.o_rsp_valid, 0);
        chk("post_cmd_ready", bus.o_cmd_ready, 1);

        chk("stb_cycles", stb_log.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < stb_log.size(); k++) begin
            obs = stb_log[k];
            if (!exp_q[k][16]) obs[7:0] = 8'h00;
            chk($sformatf("stb_fields[%0d]", k), obs, exp_q[k]);
        end
        chk("cyc_cycles", cyc_cnt, exp_lat - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected done");
        $fatal(1, "time limit");
    end

    initial begin
        int wait_n;
        rst_n           = 1'b0;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_a     = '0;
        bus.i_cmd_b     = '0;
        bus.i_cmd_carry = 1'b0;
        bus.i_rsp_ready = 1'b0;
        ref_c           = 1'b0;
        cfg_default();
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_rsp_valid, bus.o_rsp_err}, 0);
        chk("rst_data", {bus.o_wb_addr, bus.o_wb_data, bus.o_rsp_result, bus.o_rsp_flags}, 0);
        chk("rst_cmd_ready", bus.o_cmd_ready, 1);

        // basic add: 7F + 01 -> 80, flags N|V
        tick();
        run_cmd(8'h7F, 8'h01, 1'b0, 0);

        // add with carry
        tick();
        run_cmd(8'hFF, 8'h00, 1'b1, 0);

        // WR_B stalled 3 cycles
        cfg_default();
        stall_cfg[1] = 3;
        tick();
        run_cmd(8'h12, 8'h00, 1'b0, 0);

        // response back-pressure
        cfg_default();
        tick();
        run_cmd(8'h80, 8'h80, 1'b0, 5);

        // stray acks everywhere outside WAIT, with REQ stalls
        cfg_default();
        stray_mode   = 1;
        stall_cfg[0] = 1;
        stall_cfg[3] = 2;
        tick();
        run_cmd(8'h01, 8'hFF, 1'b1, 1);
        stray_mode = 0;

        // reset during RD_RES WAIT
        cfg_default();
        ack_delay = 3;
        tick();
        slave_clear();
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = 8'h3C;
        bus.i_cmd_b     = 8'h44;
        bus.i_cmd_carry = 1'b0;
        begin
            logic [15:0] rf;
            rf = alu_add(8'h3C, 8'h44, 1'b0);
            ref_c = rf[FLAG_C];
        end
        tick();
        bus.i_cmd_valid = 1'b0;
        wait_n = 0;
        forever begin
            @(negedge clk);
            if (stb_log.size() >= 4 || wait_n > 100) break;
            wait_n++;
        end
        chk("rd_res_reached", stb_log.size(), 4);
        tick();
        chk("pre_reset_cyc", bus.o_wb_cyc, 1);
        rst_n = 1'b0;
        #1;
        chk("async_drop", {bus.o_wb_cyc, bus.o_wb_stb}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_state", {bus.o_cmd_ready, bus.o_rsp_valid, bus.o_wb_cyc, bus.o_wb_stb}, 4'b1000);
        chk("post_reset_result", bus.o_rsp_result, 0);
        cfg_default();
        repeat (2) tick();
        run_cmd(8'h05, 8'h0A, 1'b0, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
        // OP never acked
        cfg_default();
        noack_op = 1;
        tick();
        run_cmd(8'h33, 8'h22, 1'b0, 0);
        cfg_default();
        tick();
        run_cmd(8'h10, 8'h20, 1'b1, 0);
`endif

        // randomized commands
        for (int n = 0; n < 12; n++) begin
            cfg_default();
            for (int k = 0; k < 5; k++) stall_cfg[k] = $urandom_range(0, 2);
            ack_delay  = $urandom_range(1, 2);
            stray_mode = (ack_delay == 1) && ($urandom_range(0, 1) == 1);
            tick();
            run_cmd(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_wb_sequencer.md
Name: alu_wb_sequencer

Overview:
- Wishbone pipelined-bus master that sits directly upstream of the 8-bit ALU slave.
- Accepts one ALU command (operands A/B plus carry-select) on a valid/ready interface.
- Runs the full bus sequence for that command:
  - write A (0x00), write B (0x01);
  - trigger read of 0x80 (add) or 0x81 (add with carry);
  - read result (RES_ADDR), read flags (FLAGS_ADDR).
- Returns result, flags and an error bit on a valid/ready response interface.
- This is the block the CPU decode/execute stage uses to drive the ALU.

Parameters:
- RES_ADDR, 8'h03, address read back to obtain the last operation result.
- FLAGS_ADDR, 8'h02, address of the flags register.
- TIMEOUT_CYCLES, 16, cycles to wait for ack per transaction (only with TIMEOUT_EN); legal range 2..255.

Ports:
- i_clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- i_cmd_a  in  8  operand A
- i_cmd_b  in  8  operand B
- i_cmd_carry  in  1  0 = add (0x80), 1 = add with carry (0x81)
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer takes response
- o_rsp_result  out  8  result byte
- o_rsp_flags  out  8  flags byte
- o_rsp_err  out  1  bus timeout occurred (always 0 without TIMEOUT_EN)
- o_wb_cyc  out  1  bus cycle active
- o_wb_stb  out  1  request strobe
- o_wb_we  out  1  write enable
- o_wb_addr  out  8  request address
- o_wb_data  out  8  write data
- i_wb_ack  in  1  slave acknowledge
- i_wb_stall  in  1  slave stall
- i_wb_data  in  8  read data, valid when i_wb_ack = 1

Behaviour:
- Clocking and reset: one clock, i_clk. reset_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid, o_rsp_err = 0.
  - o_wb_addr, o_wb_data, o_rsp_result, o_rsp_flags = 0.
  - o_cmd_ready = 1 after reset release.
- Reset mid-sequence: abandons the bus immediately (cyc/stb drop asynchronously); no response is produced.
- States: IDLE, WR_A, WR_B, OP, RD_RES, RD_FLG, RESP.
- Command capture: i_cmd_valid && o_cmd_ready in IDLE latches A, B and carry into internal registers, then enters WR_A.
- Bus states WR_A, WR_B, OP, RD_RES, RD_FLG each run one transaction:
  - Phase REQ: cyc = 1, stb = 1, we/addr/data set per state. stb is held until sampled with i_wb_stall = 0 (accepted).
  - Phase WAIT: stb = 0, cyc = 1 until i_wb_ack = 1.
  - At most one outstanding request; no pipelining across transactions.
  - An ack arriving in the same cycle as acceptance is not legal for this slave class. It is ignored in REQ.
- Per-state bus fields:
  - WR_A: we = 1, addr 0x00, data = A.
  - WR_B: we = 1, addr 0x01, data = B.
  - OP: we = 0, addr 0x80 or 0x81 per carry; read data is discarded.
  - RD_RES: we = 0, addr RES_ADDR; result <= i_wb_data on ack.
  - RD_FLG: we = 0, addr FLAGS_ADDR; flags <= i_wb_data on ack.
- Cycle behaviour between transactions:
  - cyc stays 1 across all five transactions; the next transaction's REQ starts the cycle after the previous ack.
  - cyc drops in the cycle after the RD_FLG ack.
- RESP:
  - o_rsp_valid = 1; result, flags and err held stable.
  - Leaves to IDLE on i_rsp_ready.
  - o_cmd_ready rises the cycle after the handshake; back-to-back commands therefore have a 1-cycle IDLE gap.
- Latency with a zero-stall, 1-cycle-ack slave:
  - Command accepted in cycle 0; first stb in cycle 1.
  - Acks in cycles 2, 4, 6, 8, 10.
  - o_rsp_valid = 1 from cycle 11.
  - Each stall cycle adds 1 cycle.
- Stray ack (ack while not in WAIT) is ignored.

Optional Feature:
- Macro: ALU_SEQ_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit watchdog counter clears on each acceptance and counts WAIT cycles.
  - If TIMEOUT_CYCLES WAIT cycles pass without ack: cyc/stb drop next cycle, o_rsp_err = 1, state jumps to RESP.
  - result/flags hold whatever was captured so far (0 if not yet read).
  - REQ-phase stall is not timed.
- Without the macro: no counter; WAIT waits indefinitely; o_rsp_err is tied 0.

Decomposition:
- Shared package alu_pkg holds:
  - state enum;
  - ALU address constants ADDR_A = 8'h00, ADDR_B = 8'h01, ADDR_FLAGS = 8'h02, ADDR_RES = 8'h03, ADDR_ADD = 8'h80, ADDR_ADDC = 8'h81;
  - flag bit positions C = 0, Z = 1, V = 6, N = 7.
- One sub-module, wb_single_xfer: the REQ/WAIT handshake engine (start, we, addr, data in; done, rdata, timeout out). The sequencer FSM instantiates it once.

Test Plan:
- Zero-stall slave model; cmd A = 0x7F, B = 0x01, carry = 0; slave returns RES = 0x80, FLAGS = 0xC0 -> bus addresses 00, 01, 80, 03, 02 in order; o_rsp_valid in cycle 11 with result 0x80, flags 0xC0, err 0.
- carry = 1, A = 0xFF, B = 0x00 -> OP-phase addr = 0x81; write data on WR_A = 0xFF, WR_B = 0x00.
- Slave stalls 3 cycles on WR_B -> stb held with addr 0x01, data 0x00 for 4 cycles; response delayed exactly 3 cycles (cycle 14).
- i_rsp_ready held 0 for 5 cycles -> response fields stable, o_cmd_ready = 0, no bus activity; after ready, o_cmd_ready = 1 one cycle later.
- reset_n pulsed low during RD_RES WAIT -> cyc/stb = 0 immediately; after release state = IDLE, o_rsp_valid = 0, next command runs normally.
- ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 16, slave never acks OP -> cyc drops after 16 WAIT cycles; response err = 1, result = 0x00, flags = 0x00.
